reg_alu_pipe: RTL and testbench
===============================

// Module: reg_alu_pipe
// PURPOSE
//  Parametrised register-file + ALU datapath with a 2-stage pipeline (read/execute, writeback) and valid/ready command handshake.
//  Each accepted command reads two registers, selects d_in or the ALU result, and optionally writes it back.
//  Registered carry/zero flags. Serves as the datapath core below the controller FSM.
// PARAMETERS
//  WIDTH   16  data width of registers, d_in, operands, result
//  NREGS    8  number of registers; power of two, >=2
//  AW      $clog2(NREGS)  localparam, address width (not overridable)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      block accepts command this cycle
//  sel        in   1      0: write-data = d_in, 1: write-data = ALU result
//  wr         in   1      write write-data to wr_addr at writeback
//  op         in   2      ALU op, reg_alu_pkg::alu_op_t
//  rd_addr_a  in   AW     operand A register
//  rd_addr_b  in   AW     operand B register
//  wr_addr    in   AW     destination register
//  d_in       in   WIDTH  external load data
//  d_out_a    out  WIDTH  operand A of command in execute stage
//  d_out_b    out  WIDTH  operand B of command in execute stage
//  res_valid  out  1      result/flags updated; one-cycle pulse per command
//  result     out  WIDTH  write-data of last completed command
//  cout       out  1      carry flag (registered)
//  zero       out  1      result==0 flag (registered)
// BEHAVIOUR
//  Reset (reset==0, async): all registers, d_out_a/b, result, cout, zero, res_valid = 0; execute stage invalid; an in-flight command is dropped with no writeback.
//  Accept: command transfers on rising clk when cmd_valid && cmd_ready; register file read at that edge into execute stage (d_out_a/b, op, sel, wr, wr_addr, d_in).
//  Execute: ALU is combinational on d_out_a/b; no downstream backpressure.
//  Writeback: at the next edge, if wr, reg[wr_addr] <= write-data. result <= write-data. res_valid = 1 for one cycle.
//  Latency: accept edge N -> res_valid high after edge N+1. Throughput: 1 command/cycle when there is no stall.
//  ALU ops (WIDTH-bit, modulo 2^WIDTH):
//   00 ADD: {cout,res} = a + b
//   01 SUB: res = a - b; cout = (a >= b) unsigned, i.e. no-borrow
//   10 AND, 11 OR: cout unchanged
//  Flags: cout updates only when sel=1 and op is ADD/SUB. zero updates every writeback.
//  Hazard: the execute stage holds a write (wr=1) to addr X, and the incoming command reads X on port A or B. Handling depends on CONFIGURATION.
//  Same-cycle writeback to X and read of X: the read returns the old value (write and read share the same edge).
//  wr=0 commands complete normally and leave the file unchanged. Register 0 is a normal register.
//  cmd_ready does not depend on cmd_valid, so there is no combinational loop.
// CONFIGURATION
//  REG_ALU_BYPASS_EN defined:
//   - Execute-stage write-data is forwarded to the matching operand at accept.
//   - cmd_ready = 1 whenever out of reset.
//  REG_ALU_BYPASS_EN undefined:
//   - cmd_ready = 0 while a hazard exists. This gives a one-cycle stall; the command is accepted on the next edge after writeback.
// STRUCTURE
//  reg_alu_pkg:
//   - typedef enum logic [1:0] alu_op_t {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR}
//   - WIDTH_DEF=16, NREGS_DEF=8
//  Sub-module reg_file_p #(WIDTH, NREGS):
//   - async active-low reset, 2 combinational read ports, 1 synchronous write port with enable
//   - instantiated once
//  The execute-stage register, ALU, flags and hazard/bypass logic are in the top level.
// TESTING
//  1. Reset mid-command: accept (sel=0, wr=1, d_in=0x1234, wr_addr=3), assert reset before writeback -> reg3 stays 0, res_valid never pulses, all outputs 0.
//  2. Load + ADD: load r1=0xFFFF, r2=0x0001, then ADD r1,r2->r4 -> result=0x0000, cout=1, zero=1, r4=0.
//  3. SUB borrow: r1=0x0003, r2=0x0005, SUB r1,r2->r5 -> result=0xFFFE, cout=0, zero=0. Then AND r1,r1 -> cout stays 0.
//  4. Back-to-back RAW: load r6=0x00AA, then next cycle ADD r6,r6->r7.
//   - With REG_ALU_BYPASS_EN: no stall, r7=0x0154.
//   - Without it: cmd_ready=0 for exactly 1 cycle, r7=0x0154.
//  5. Streaming: 8 loads with cmd_valid held high, wr_addr 0..7, d_in=addr*0x11 -> 8 consecutive res_valid pulses, every register correct, no stalls.
//  6. Parameter sweep: WIDTH=8, NREGS=4, ADD 0xF0+0x20 -> result=0x10, cout=1; address wrap on the AW=2 ports verified.

Source files
------------

// File: rtl/reg_alu_pipe_pkg.sv
// Shared types and defaults for the register-file + ALU datapath.
package reg_alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    localparam int WIDTH_DEF = 16;
    localparam int NREGS_DEF = 8;

    // Only the arithmetic ops produce a meaningful carry/no-borrow.
    function automatic logic op_sets_carry(input alu_op_t op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/reg_alu_pipe_if.sv
// Command/result bundle of reg_alu_pipe; master drives commands, slave is the datapath.
interface reg_alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    import reg_alu_pkg::*;
    localparam int AW = $clog2(NREGS);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             sel;
    logic             wr;
    alu_op_t          op;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out_a;
    logic [WIDTH-1:0] d_out_b;
    logic             res_valid;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;

    modport master (
        output cmd_valid, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        input  cmd_ready, d_out_a, d_out_b, res_valid, result, cout, zero
    );

    modport slave (
        input  cmd_valid, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        output cmd_ready, d_out_a, d_out_b, res_valid, result, cout, zero
    );

endinterface

// File: rtl/reg_alu_pipe_reg_file.sv
// Register file: async active-low reset, two combinational read ports, one synchronous write port.
module reg_file_p #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] regs_q [NREGS];

    // Storage array with clear on reset and single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // A read in the same cycle as a write sees the pre-write value.
    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/reg_alu_pipe.sv
// Two-stage register-file + ALU datapath (read/execute, writeback) with valid/ready commands.
// Define REG_ALU_BYPASS_EN to forward execute-stage write-data instead of stalling on RAW hazards.
module reg_alu_pipe #(
    parameter int WIDTH = reg_alu_pkg::WIDTH_DEF,
    parameter int NREGS = reg_alu_pkg::NREGS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    reg_alu_pipe_if.slave  bus
);
    import reg_alu_pkg::*;
    localparam int AW = $clog2(NREGS);

    logic             ex_valid_q, ex_sel_q, ex_wr_q;
    alu_op_t          ex_op_q;
    logic [AW-1:0]    ex_waddr_q;
    logic [WIDTH-1:0] ex_din_q, a_q, b_q, a_d, b_d;
    logic [WIDTH-1:0] rf_a_s, rf_b_s, alu_res_s, wdata_s, result_q;
    logic             alu_c_s, res_valid_q, cout_q, zero_q;
    logic             hazard_a_s, hazard_b_s, ready_s, accept_s;

    assign hazard_a_s = ex_valid_q && ex_wr_q && (bus.rd_addr_a == ex_waddr_q);
    assign hazard_b_s = ex_valid_q && ex_wr_q && (bus.rd_addr_b == ex_waddr_q);
    assign accept_s   = bus.cmd_valid && ready_s;

    reg_file_p #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk       (clk),
        .rst_n     (reset),
        .we_i      (ex_valid_q && ex_wr_q),
        .waddr_i   (ex_waddr_q),
        .wdata_i   (wdata_s),
        .raddr_a_i (bus.rd_addr_a),
        .raddr_b_i (bus.rd_addr_b),
        .rdata_a_o (rf_a_s),
        .rdata_b_o (rf_b_s)
    );

    // ALU on the execute-stage operands; carry defaults to the held flag.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = cout_q;
        case (ex_op_q)
            ALU_ADD: {alu_c_s, alu_res_s} = {1'b0, a_q} + {1'b0, b_q};
            ALU_SUB: begin
                alu_res_s = a_q - b_q;
                alu_c_s   = (a_q >= b_q);
            end
            ALU_AND: alu_res_s = a_q & b_q;
            ALU_OR:  alu_res_s = a_q | b_q;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign wdata_s = ex_sel_q ? alu_res_s : ex_din_q;

`ifdef REG_ALU_BYPASS_EN
    // Forward the write-data in flight to any operand that reads its destination.
    always_comb begin
        a_d     = hazard_a_s ? wdata_s : rf_a_s;
        b_d     = hazard_b_s ? wdata_s : rf_b_s;
        ready_s = reset;
    end
`else
    // Hold off a reader of the in-flight destination until it has been written.
    always_comb begin
        a_d     = rf_a_s;
        b_d     = rf_b_s;
        ready_s = reset && !(hazard_a_s || hazard_b_s);
    end
`endif

    // Execute-stage capture at accept, writeback of result and flags one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_sel_q    <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_op_q     <= ALU_ADD;
            ex_waddr_q  <= {AW{1'b0}};
            ex_din_q    <= {WIDTH{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            res_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            ex_valid_q  <= accept_s;
            res_valid_q <= ex_valid_q;
            if (accept_s) begin
                ex_sel_q   <= bus.sel;
                ex_wr_q    <= bus.wr;
                ex_op_q    <= bus.op;
                ex_waddr_q <= bus.wr_addr;
                ex_din_q   <= bus.d_in;
                a_q        <= a_d;
                b_q        <= b_d;
            end
            if (ex_valid_q) begin
                result_q <= wdata_s;
                zero_q   <= (wdata_s == {WIDTH{1'b0}});
                if (ex_sel_q && op_sets_carry(ex_op_q)) begin
                    cout_q <= alu_c_s;
                end
            end
        end
    end

    assign bus.cmd_ready = ready_s;
    assign bus.d_out_a   = a_q;
    assign bus.d_out_b   = b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed, table-driven bench for reg_alu_pipe (16x8 instance plus an 8-bit x 4 instance).
module tb_reg_alu_pipe;
    import reg_alu_pkg::*;

`ifdef REG_ALU_BYPASS_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    logic clk;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [15:0] model_rf [8];

    reg_alu_pipe_if #(.WIDTH(16), .NREGS(8)) bus  ();
    reg_alu_pipe_if #(.WIDTH(8),  .NREGS(4)) bus8 ();

    reg_alu_pipe #(.WIDTH(16), .NREGS(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
    reg_alu_pipe #(.WIDTH(8),  .NREGS(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        wr;
        alu_op_t     op;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  wa;
        logic [15:0] din;
        logic [15:0] exp_res;
        logic        exp_c;
        logic        exp_z;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a command at a negedge, wait (bounded) for acceptance, return at the next negedge.
    task automatic send(input logic sel, input logic wr, input alu_op_t op,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] wa,
                        input logic [15:0] din);
        int n;
        bus.sel = sel; bus.wr = wr; bus.op = op;
        bus.rd_addr_a = ra; bus.rd_addr_b = rb; bus.wr_addr = wa; bus.d_in = din;
        bus.cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] addr);
        send(1'b0, 1'b0, ALU_ADD, addr, addr, 3'd0, 16'h5A5A);
        check($sformatf("reg%0d", addr), {16'd0, bus.d_out_a}, {16'd0, model_rf[addr]});
        @(negedge clk);
    endtask

    task automatic send8(input logic sel, input logic wr, input alu_op_t op,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] wa,
                         input logic [7:0] din, output logic [7:0] da, output logic [7:0] db);
        int n;
        bus8.sel = sel; bus8.wr = wr; bus8.op = op;
        bus8.rd_addr_a = ra; bus8.rd_addr_b = rb; bus8.wr_addr = wa; bus8.d_in = din;
        bus8.cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!bus8.cmd_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) check("send8_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus8.cmd_valid = 1'b0;
        da = bus8.d_out_a;
        db = bus8.d_out_b;
        @(negedge clk);
    endtask

    initial begin
        int          stalls;
        int          pulses;
        logic [2:0]  idx;
        logic [1:0]  a8;
        logic [7:0]  da8, db8;

        // sel wr op ra rb wa din | result cout zero
        vecs[0]  = '{1'b0, 1'b1, ALU_ADD, 3'd0, 3'd0, 3'd1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, ALU_ADD, 3'd1, 3'd0, 3'd2, 16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, ALU_ADD, 3'd1, 3'd2, 3'd4, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, ALU_ADD, 3'd0, 3'd0, 3'd1, 16'h0003, 16'h0003, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, ALU_ADD, 3'd0, 3'd0, 3'd2, 16'h0005, 16'h0005, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, ALU_SUB, 3'd1, 3'd2, 3'd5, 16'h0000, 16'hFFFE, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, ALU_AND, 3'd1, 3'd1, 3'd0, 16'h0000, 16'h0003, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, ALU_OR,  3'd1, 3'd2, 3'd3, 16'h0000, 16'h0007, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, ALU_SUB, 3'd2, 3'd1, 3'd6, 16'h0000, 16'h0002, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, ALU_SUB, 3'd1, 3'd1, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, ALU_ADD, 3'd4, 3'd5, 3'd7, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, ALU_ADD, 3'd5, 3'd2, 3'd0, 16'h0000, 16'h0003, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, ALU_AND, 3'd4, 3'd5, 3'd6, 16'h0000, 16'h0000, 1'b1, 1'b1};

        for (int i = 0; i < 8; i++) model_rf[i] = 16'd0;
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.sel = 1'b0; bus.wr = 1'b0; bus.op = ALU_ADD;
        bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd0; bus.wr_addr = 3'd0; bus.d_in = 16'd0;
        bus8.cmd_valid = 1'b0; bus8.sel = 1'b0; bus8.wr = 1'b0; bus8.op = ALU_ADD;
        bus8.rd_addr_a = 2'd0; bus8.rd_addr_b = 2'd0; bus8.wr_addr = 2'd0; bus8.d_in = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_ready",     {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_result",    {16'd0, bus.result},    32'd0);
        check("rst_flags",     {30'd0, bus.cout, bus.zero}, 32'd0);
        reset = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);

        // Sequential vectors: operands, one-cycle result pulse, flags.
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].sel, vecs[i].wr, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].wa, vecs[i].din);
            check($sformatf("v%0d_opa", i), {16'd0, bus.d_out_a}, {16'd0, model_rf[vecs[i].ra]});
            check($sformatf("v%0d_opb", i), {16'd0, bus.d_out_b}, {16'd0, model_rf[vecs[i].rb]});
            @(negedge clk);
            check($sformatf("v%0d_valid", i),  {31'd0, bus.res_valid}, 32'd1);
            check($sformatf("v%0d_result", i), {16'd0, bus.result}, {16'd0, vecs[i].exp_res});
            check($sformatf("v%0d_cout", i),   {31'd0, bus.cout}, {31'd0, vecs[i].exp_c});
            check($sformatf("v%0d_zero", i),   {31'd0, bus.zero}, {31'd0, vecs[i].exp_z});
            if (vecs[i].wr) model_rf[vecs[i].wa] = vecs[i].exp_res;
            @(negedge clk);
            check($sformatf("v%0d_pulse_end", i), {31'd0, bus.res_valid}, 32'd0);
        end
        for (int r = 0; r < 8; r++) read_reg(r[2:0]);

        // Reset with a load to r3 in flight: no writeback, no pulse, everything cleared.
        send(1'b0, 1'b1, ALU_ADD, 3'd5, 3'd3, 3'd3, 16'h1234);
        reset = 1'b0;
        #1;
        check("midrst_opa",    {16'd0, bus.d_out_a}, 32'd0);
        check("midrst_opb",    {16'd0, bus.d_out_b}, 32'd0);
        check("midrst_flags",  {30'd0, bus.cout, bus.zero}, 32'd0);
        check("midrst_result", {16'd0, bus.result}, 32'd0);
        check("midrst_ready",  {31'd0, bus.cmd_ready}, 32'd0);
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.res_valid) pulses++;
        end
        reset = 1'b1;
        @(negedge clk);
        if (bus.res_valid) pulses++;
        check("midrst_no_pulse", pulses, 32'd0);
        for (int i = 0; i < 8; i++) model_rf[i] = 16'd0;
        read_reg(3'd3);
        read_reg(3'd5);

        // Back-to-back RAW: load r6 then immediately ADD r6,r6 -> r7.
        bus.sel = 1'b0; bus.wr = 1'b1; bus.op = ALU_ADD;
        bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd0; bus.wr_addr = 3'd6; bus.d_in = 16'h00AA;
        bus.cmd_valid = 1'b1;
        #1;
        check("raw_load_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        bus.sel = 1'b1; bus.rd_addr_a = 3'd6; bus.rd_addr_b = 3'd6; bus.wr_addr = 3'd7; bus.d_in = 16'd0;
        #1;
        stalls = 0;
        while (!bus.cmd_ready && stalls < 5) begin
            @(negedge clk); #1; stalls++;
        end
        check("raw_stalls", stalls, EXP_STALL);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("raw_opa", {16'd0, bus.d_out_a}, 32'h00AA);
        check("raw_opb", {16'd0, bus.d_out_b}, 32'h00AA);
        @(negedge clk);
        check("raw_result", {16'd0, bus.result}, 32'h0154);
        check("raw_cout",   {31'd0, bus.cout}, 32'd0);
        model_rf[6] = 16'h00AA;
        model_rf[7] = 16'h0154;
        @(negedge clk);
        read_reg(3'd7);
        read_reg(3'd6);
        @(negedge clk);

        // Streaming: eight loads with cmd_valid held high.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.res_valid) pulses++;
            if (i >= 2) check($sformatf("stream_res%0d", i - 2), {16'd0, bus.result}, (i - 2) * 32'h11);
            if (i < 8) begin
                idx = i[2:0];
                bus.sel = 1'b0; bus.wr = 1'b1; bus.op = ALU_ADD;
                bus.rd_addr_a = idx + 3'd4; bus.rd_addr_b = idx + 3'd4;
                bus.wr_addr = idx; bus.d_in = 16'(i * 16'h11);
                bus.cmd_valid = 1'b1;
                model_rf[idx] = 16'(i * 16'h11);
                #1;
                check($sformatf("stream_ready%0d", i), {31'd0, bus.cmd_ready}, 32'd1);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_pulses", pulses, 32'd8);
        check("stream_idle",   {31'd0, bus.res_valid}, 32'd0);
        for (int r = 0; r < 8; r++) read_reg(r[2:0]);

        // 8-bit x 4-register instance: carry out of ADD and address wrap.
        send8(1'b0, 1'b1, ALU_ADD, 2'd0, 2'd0, 2'd1, 8'hF0, da8, db8);
        send8(1'b0, 1'b1, ALU_ADD, 2'd0, 2'd0, 2'd2, 8'h20, da8, db8);
        send8(1'b1, 1'b1, ALU_ADD, 2'd1, 2'd2, 2'd3, 8'h00, da8, db8);
        check("w8_opa",    {24'd0, da8}, 32'hF0);
        check("w8_opb",    {24'd0, db8}, 32'h20);
        check("w8_result", {24'd0, bus8.result}, 32'h10);
        check("w8_cout",   {31'd0, bus8.cout}, 32'd1);
        check("w8_zero",   {31'd0, bus8.zero}, 32'd0);
        send8(1'b0, 1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 8'h5C, da8, db8);
        a8 = 2'd3;
        a8 = a8 + 2'd1;
        send8(1'b0, 1'b0, ALU_ADD, a8, 2'd3, 2'd0, 8'h00, da8, db8);
        check("w8_wrap_r0", {24'd0, da8}, 32'h5C);
        check("w8_r3",      {24'd0, db8}, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
